// File: rtl/adpll_sweep_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : adpll_sweep_ctrl_pkg
// Purpose : Shared definitions for the ADPLL sweep controller: sequencer state
//           encoding, default widths and a signed-magnitude helper.
// Ports   : none (package)
// Config  : SWEEP_LOOP_EN is consumed by adpll_sweep_ctrl, not here.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package adpll_sweep_ctrl_pkg;

   localparam int ACCUM_WIDTH_DEF = 12;
   localparam int ERR_WIDTH_DEF   = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_ACQUIRE = 3'd2,
      ST_REPORT  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Absolute value of a sign-extended error. Callers extend narrow errors to
   // 32 bits first, so the most-negative narrow value maps to its true
   // magnitude (e.g. -128 -> 128) without wrapping.
   function automatic logic [31:0] abs32(input logic signed [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/adpll_sweep_ctrl_lock_detect.sv
//------------------------------------------------------------------------------
// Module  : adpll_lock_detect
// Purpose : Counts consecutive cycles with |error| <= LOCK_TOL and flags lock
//           in the cycle the run reaches LOCK_COUNT.
// Ports   : clk      - clock
//           rst      - synchronous active-high reset
//           i_clear  - synchronous clear of the run counter
//           i_error  - signed ADPLL phase error
//           o_locked - combinational: this cycle completes the in-lock run
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module adpll_lock_detect
   import adpll_sweep_ctrl_pkg::*;
#(
   parameter int ERR_WIDTH  = ERR_WIDTH_DEF,
   parameter int LOCK_TOL   = 2,
   parameter int LOCK_COUNT = 64
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clear,
   input  logic [ERR_WIDTH-1:0] i_error,
   output logic                 o_locked
);

   // Counter only needs to hold 0..LOCK_COUNT-1: the cycle that would reach
   // LOCK_COUNT is reported through o_locked instead of being stored.
   localparam int c_CNT_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT);

   logic signed [31:0] w_err_ext;
   logic [31:0]        w_err_abs;
   logic               w_in_lock;
   logic [c_CNT_W-1:0] r_cnt;

   assign w_err_ext = 32'(signed'(i_error));
   assign w_err_abs = abs32(w_err_ext);
   assign w_in_lock = (w_err_abs <= 32'(LOCK_TOL));
   assign o_locked  = w_in_lock && (r_cnt == c_CNT_W'(LOCK_COUNT - 1));

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
      end else if (!w_in_lock) begin
         r_cnt <= '0;
      end else if (!o_locked) begin
         r_cnt <= r_cnt + c_CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/adpll_sweep_ctrl.sv
//------------------------------------------------------------------------------
// Module  : adpll_sweep_ctrl
// Purpose : Steps the PhaseAccum tuning word from k_start to k_stop, holds the
//           ADPLL disabled for SETTLE_CYC cycles after every change, then times
//           acquisition until lock or TIMEOUT_CYC and reports per step.
// Ports   : fpga_clk_i/reset_i        clock, synchronous active-high reset
//           start_i/abort_i           sweep start pulse, abort level
//           k_start_i/k_stop_i/k_step_i sweep range, latched on accepted start
//           error_i                   signed ADPLL phase error
//           k_val_o/adpll_enable_o    tuning word and ADPLL enable
//           busy_o/done_o             activity flag, end-of-sweep pulse
//           result_valid_o/lock_ok_o/lock_time_o  per-step result
// Config  : SWEEP_LOOP_EN - when defined, the sweep restarts from the latched
//           k_start after every done_o until abort/reset.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module adpll_sweep_ctrl
   import adpll_sweep_ctrl_pkg::*;
#(
   parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEF,
   parameter int ERR_WIDTH   = ERR_WIDTH_DEF,
   parameter int LOCK_TOL    = 2,
   parameter int LOCK_COUNT  = 64,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 65535,
   parameter int CNT_WIDTH   = 16
)(
   input  logic                   fpga_clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [ACCUM_WIDTH-1:0] k_start_i,
   input  logic [ACCUM_WIDTH-1:0] k_stop_i,
   input  logic [ACCUM_WIDTH-1:0] k_step_i,
   input  logic [ERR_WIDTH-1:0]   error_i,
   output logic [ACCUM_WIDTH-1:0] k_val_o,
   output logic                   adpll_enable_o,
   output logic                   busy_o,
   output logic                   result_valid_o,
   output logic                   lock_ok_o,
   output logic [CNT_WIDTH-1:0]   lock_time_o,
   output logic                   done_o
);

   localparam int c_SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

   state_t                 r_state;
   state_t                 w_next_state;
   logic [c_SET_W-1:0]     r_settle_cnt;
   logic [CNT_WIDTH-1:0]   r_time_cnt;
   logic [ACCUM_WIDTH-1:0] r_k_val;
   logic [ACCUM_WIDTH-1:0] r_k_stop;
   logic [ACCUM_WIDTH-1:0] r_k_step;
`ifdef SWEEP_LOOP_EN
   logic [ACCUM_WIDTH-1:0] r_k_start;
`endif
   logic                   r_lock_ok;
   logic [CNT_WIDTH-1:0]   r_lock_time;
   logic                   w_locked;
   logic                   w_timeout;
   logic                   w_sweep_end;
   logic [ACCUM_WIDTH:0]   w_next_k;

   // One bit wider than k so a wrap past the top of the tuning range shows up
   // as a carry and ends the sweep instead of restarting from a small value.
   assign w_next_k    = {1'b0, r_k_val} + {1'b0, r_k_step};
   assign w_sweep_end = (r_k_step == '0) || w_next_k[ACCUM_WIDTH] ||
                        (w_next_k[ACCUM_WIDTH-1:0] > r_k_stop);
   assign w_timeout   = (r_time_cnt == CNT_WIDTH'(TIMEOUT_CYC - 1));

   adpll_lock_detect #(
      .ERR_WIDTH  (ERR_WIDTH),
      .LOCK_TOL   (LOCK_TOL),
      .LOCK_COUNT (LOCK_COUNT)
   ) u_lock_detect (
      .clk      (fpga_clk_i),
      .rst      (reset_i),
      .i_clear  (r_state != ST_ACQUIRE),
      .i_error  (error_i),
      .o_locked (w_locked)
   );

   always_ff @(posedge fpga_clk_i) begin
      if (reset_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state   = r_state;
      adpll_enable_o = 1'b0;
      busy_o         = 1'b1;
      result_valid_o = 1'b0;
      done_o         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy_o = 1'b0;
            if (start_i) w_next_state = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (r_settle_cnt == c_SET_W'(SETTLE_CYC - 1)) w_next_state = ST_ACQUIRE;
         end
         ST_ACQUIRE: begin
            adpll_enable_o = 1'b1;
            if (w_locked || w_timeout) w_next_state = ST_REPORT;
         end
         ST_REPORT: begin
            result_valid_o = !abort_i;
            w_next_state   = w_sweep_end ? ST_DONE : ST_SETTLE;
         end
         ST_DONE: begin
            done_o = !abort_i;
`ifdef SWEEP_LOOP_EN
            w_next_state = ST_SETTLE;
`else
            w_next_state = ST_IDLE;
`endif
         end
         default: w_next_state = ST_IDLE;
      endcase
      // Abort outranks every transition, including an accepted start.
      if (abort_i) w_next_state = ST_IDLE;
   end

   always_ff @(posedge fpga_clk_i) begin
      if (reset_i) begin
         r_settle_cnt <= '0;
         r_time_cnt   <= '0;
         r_k_val      <= '0;
         r_k_stop     <= '0;
         r_k_step     <= '0;
`ifdef SWEEP_LOOP_EN
         r_k_start    <= '0;
`endif
         r_lock_ok    <= 1'b0;
         r_lock_time  <= '0;
      end else begin
         // Both counters restart at 0 on every entry into their state.
         r_settle_cnt <= (r_state == ST_SETTLE && w_next_state == ST_SETTLE) ?
                         r_settle_cnt + c_SET_W'(1) : '0;
         r_time_cnt   <= (r_state == ST_ACQUIRE && w_next_state == ST_ACQUIRE) ?
                         r_time_cnt + CNT_WIDTH'(1) : '0;

         if (r_state == ST_IDLE && w_next_state == ST_SETTLE) begin
            r_k_val   <= k_start_i;
            r_k_stop  <= k_stop_i;
            r_k_step  <= k_step_i;
`ifdef SWEEP_LOOP_EN
            r_k_start <= k_start_i;
`endif
         end

         // Lock wins over a coincident timeout.
         if (r_state == ST_ACQUIRE && w_next_state == ST_REPORT) begin
            r_lock_ok   <= w_locked;
            r_lock_time <= w_locked ? r_time_cnt : CNT_WIDTH'(TIMEOUT_CYC);
         end

         if (r_state == ST_REPORT && w_next_state == ST_SETTLE) begin
            r_k_val <= w_next_k[ACCUM_WIDTH-1:0];
         end

`ifdef SWEEP_LOOP_EN
         if (r_state == ST_DONE && w_next_state == ST_SETTLE) begin
            r_k_val <= r_k_start;
         end
`endif
      end
   end

   assign k_val_o     = r_k_val;
   assign lock_ok_o   = r_lock_ok;
   assign lock_time_o = r_lock_time;

endmodule

`default_nettype wire
